// File: rtl/aluctrl_pkg.sv
// aluctrl_pkg: shared aluop/ALU-op/M-extension encodings and sequencer state type
package aluctrl_pkg;
  localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SLTU = 2'b01, ALUOP_FUNCT = 2'b10, ALUOP_IMM = 2'b11;
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b1000, ALU_SLL = 4'b0001, ALU_SLT = 4'b0010,
                         ALU_SLTU = 4'b0011, ALU_XOR = 4'b0100, ALU_SRL = 4'b0101, ALU_SRA = 4'b1101,
                         ALU_OR = 4'b0110, ALU_AND = 4'b0111;
  localparam logic [2:0] F3_MUL = 3'b000, F3_MULH = 3'b001, F3_MULHSU = 3'b010, F3_MULHU = 3'b011,
                         F3_DIV = 3'b100, F3_DIVU = 3'b101, F3_REM = 3'b110, F3_REMU = 3'b111;
  localparam logic [6:0] M_FUNCT7 = 7'b0000001;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_t;
endpackage

// File: rtl/aluctrl_md_if.sv
// aluctrl_md_if: EX-stage control/operand bundle between the pipeline and aluctrl_md
interface aluctrl_md_if #(parameter int XLEN = 32);
  logic            valid_ip;
  logic            flush_ip;
  logic [1:0]      ctrl_aluop_ip;
  logic [2:0]      funct3_ip;
  logic [6:0]      funct7_ip;
  logic [XLEN-1:0] rs1_ip;
  logic [XLEN-1:0] rs2_ip;
  logic [3:0]      aluctrl_ctrl_op;
  logic            md_busy_op;
  logic            md_valid_op;
  logic [XLEN-1:0] md_result_op;
  modport master(output valid_ip, flush_ip, ctrl_aluop_ip, funct3_ip, funct7_ip, rs1_ip, rs2_ip,
                 input aluctrl_ctrl_op, md_busy_op, md_valid_op, md_result_op);
  modport slave(input valid_ip, flush_ip, ctrl_aluop_ip, funct3_ip, funct7_ip, rs1_ip, rs2_ip,
                output aluctrl_ctrl_op, md_busy_op, md_valid_op, md_result_op);
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative RV32M shift-add multiplier / restoring divider with FSM.
// ALUCTRL_MD_EARLY_OUT_EN: finish MUL as soon as the remaining multiplier is zero.
module alu_muldiv_seq import aluctrl_pkg::*; #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_idle,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  md_state_t         r_state, w_state_nxt;
  logic [2*XLEN-1:0] r_acc, r_opb, w_acc_nxt, w_mul_acc, w_div_acc, w_prod;
  logic [XLEN-1:0]   r_mplier, w_mplier_nxt, r_result, w_final, w_ma, w_mb, w_dv, w_spec_res;
  logic [XLEN:0]     w_shift, w_diff;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [2:0]        r_f3;
  logic              r_neg, r_spec, w_sa, w_sb, w_div0, w_ovf, w_run, w_last;
  // Operand conditioning at capture: signed ops work on magnitudes, sign fixed at the end
  assign w_sa = (i_funct3 == F3_MULH || i_funct3 == F3_MULHSU || i_funct3 == F3_DIV || i_funct3 == F3_REM) && i_rs1[XLEN-1];
  assign w_sb = (i_funct3 == F3_MULH || i_funct3 == F3_DIV || i_funct3 == F3_REM) && i_rs2[XLEN-1];
  assign w_ma = w_sa ? -i_rs1 : i_rs1;
  assign w_mb = w_sb ? -i_rs2 : i_rs2;
  assign w_div0 = i_funct3[2] && i_rs2 == '0;
  assign w_ovf = (i_funct3 == F3_DIV || i_funct3 == F3_REM) && i_rs1 == {1'b1, {(XLEN-1){1'b0}}} && &i_rs2;
  assign w_spec_res = w_div0 ? (i_funct3[1] ? i_rs1 : '1) : (i_funct3[1] ? '0 : i_rs1);
  assign w_mul_acc = r_mplier[0] ? r_acc + r_opb : r_acc;
  assign w_shift = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff = w_shift - {1'b0, r_opb[XLEN-1:0]};
  assign w_div_acc = w_diff[XLEN] ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0} : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_acc_nxt = r_state == DIV ? w_div_acc : w_mul_acc;
  assign w_mplier_nxt = r_mplier >> 1;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_run = o_busy && !r_spec;
`ifdef ALUCTRL_MD_EARLY_OUT_EN
  assign w_last = w_cnt_nxt == CNT_W'(XLEN) || r_spec || (r_state == MUL && w_mplier_nxt == '0);
`else
  assign w_last = w_cnt_nxt == CNT_W'(XLEN) || r_spec;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_opb    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_spec   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_start) begin
        r_f3     <= i_funct3;
        r_neg    <= (i_funct3[2] && i_funct3[1]) ? w_sa : w_sa ^ w_sb;
        r_spec   <= w_div0 || w_ovf;
        r_cnt    <= '0;
        r_acc    <= (w_div0 || w_ovf) ? {{XLEN{1'b0}}, w_spec_res} : i_funct3[2] ? {{XLEN{1'b0}}, w_ma} : '0;
        r_opb    <= {{XLEN{1'b0}}, i_funct3[2] ? w_mb : w_ma};
        r_mplier <= w_mb;
      end else if (w_run) begin
        r_acc    <= w_acc_nxt;
        r_opb    <= r_state == MUL ? r_opb << 1 : r_opb;
        r_mplier <= w_mplier_nxt;
        r_cnt    <= w_cnt_nxt;
      end
      if (o_valid) r_result <= w_final;
    end
  always_comb
    w_state_nxt = i_flush ? IDLE :
                  r_state == IDLE ? (i_start ? (i_funct3[2] ? DIV : MUL) : IDLE) :
                  r_state == DONE ? IDLE :
                  w_last ? DONE : r_state;
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_dv = r_f3[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
  assign w_final = r_spec ? r_acc[XLEN-1:0] :
                   r_f3[2] ? (r_neg ? -w_dv : w_dv) :
                   r_f3[1:0] == 2'b00 ? r_acc[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  always_comb begin
    o_idle   = r_state == IDLE;
    o_busy   = r_state == MUL || r_state == DIV;
    o_valid  = r_state == DONE && !i_flush;
    o_result = o_valid ? w_final : r_result;
  end
endmodule

// File: rtl/aluctrl_md.sv
// aluctrl_md: RV32 ALU control decode plus RV32M multiply/divide sequencer front end.
// ALUCTRL_MD_EARLY_OUT_EN (optional): early MUL completion inside alu_muldiv_seq.
module aluctrl_md import aluctrl_pkg::*; #(parameter int XLEN = 32) (
  input logic         clk,
  input logic         rst_n,
  aluctrl_md_if.slave bus
);
  logic w_start, w_idle, w_busy, w_sra;
  assign w_sra = bus.funct3_ip == 3'b101 && bus.funct7_ip[5];
  assign bus.aluctrl_ctrl_op = bus.ctrl_aluop_ip == ALUOP_SLTU  ? ALU_SLTU :
                               bus.ctrl_aluop_ip == ALUOP_FUNCT ? {bus.funct7_ip[5], bus.funct3_ip} :
                               bus.ctrl_aluop_ip == ALUOP_IMM   ? {w_sra, bus.funct3_ip} : ALU_ADD;
  // Start is qualified with rst_n so the stall request is also low while reset is held
  assign w_start = rst_n && bus.valid_ip && bus.ctrl_aluop_ip == ALUOP_FUNCT && bus.funct7_ip == M_FUNCT7 &&
                   w_idle && !bus.flush_ip;
  assign bus.md_busy_op = w_start || w_busy;
  alu_muldiv_seq #(.XLEN(XLEN)) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_flush  (bus.flush_ip),
    .i_funct3 (bus.funct3_ip),
    .i_rs1    (bus.rs1_ip),
    .i_rs2    (bus.rs2_ip),
    .o_idle   (w_idle),
    .o_busy   (w_busy),
    .o_valid  (bus.md_valid_op),
    .o_result (bus.md_result_op)
  );
endmodule

// File: doc/aluctrl_md.md
Name: aluctrl_md

Overview:
- Second-generation ALU control block for the RV32 core.
- Decodes aluop/funct into the 4-bit single-cycle ALU operation, as before, and now also defines aluop 11 for I-type ALU ops.
- Adds an XLEN-parametrised iterative multiply/divide sequencer for RV32M.
- Sits between the main control unit and the EX stage; stalls the pipeline via md_busy_op while an M-extension op is in flight.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, ≥ 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- valid_ip  in  1  EX-stage instruction valid
- flush_ip  in  1  pipeline flush; aborts the sequencer
- ctrl_aluop_ip  in  2  aluop from main control
- funct3_ip  in  3  instruction funct3
- funct7_ip  in  7  instruction funct7
- rs1_ip  in  XLEN  operand A
- rs2_ip  in  XLEN  operand B
- aluctrl_ctrl_op  out  4  single-cycle ALU operation
- md_busy_op  out  1  stall request
- md_valid_op  out  1  M-extension result valid (1-cycle pulse)
- md_result_op  out  XLEN  M-extension result

Behaviour:
- ALU op encoding is {funct7[5], funct3}:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100
  - SRL 0101, SRA 1101, OR 0110, AND 0111
- aluop decode (combinational):
  - 00 → ADD
  - 01 → SLTU
  - 10 → {funct7[5], funct3}
  - 11 (I-type) → {funct3==101 ? funct7[5] : 0, funct3}
  - Any unlisted code → ADD; never X.
- md_start = valid_ip & aluop==10 & funct7==0000001 & state==IDLE & !flush_ip.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE --start, funct3[2]=0--> MUL; IDLE --start, funct3[2]=1--> DIV.
  - MUL/DIV --counter reaches XLEN--> DONE.
  - DONE → IDLE unconditionally.
  - Any state --flush_ip--> IDLE on the next edge. No md_valid_op is issued and stale results are not presented.
- md_busy_op = md_start | (state∈{MUL,DIV}). It is combinational on the start cycle so the issuing instruction stalls immediately, and it is low in DONE so the pipeline advances with the result.
- At start, capture operand magnitudes, the result-negate flag and the op type:
  - MUL: signed×signed for MULH; signed×unsigned for MULHSU; unsigned for MUL/MULHU.
  - DIV/REM: signed; DIVU/REMU: unsigned.
- MUL datapath: radix-2 shift-add. 2*XLEN accumulator; multiplicand is 2*XLEN and shifts left, multiplier shifts right; one bit per cycle.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half of the sign-corrected product.
- DIV datapath: restoring, one quotient bit per cycle.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Remainder sign follows the dividend.
- Latency: start at cycle 0, md_valid_op=1 at cycle XLEN+1 in DONE, i.e. XLEN+1 cycles.
- Special cases are detected at capture and go MUL/DIV→DONE after 1 iteration (result at cycle 2):
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = rs1; remainder = 0.
- md_result_op is held from DONE until the next start; it reads 0 after reset.
- valid_ip while busy is ignored; the stalled pipeline holds its inputs.
- Reset (async, any state): state=IDLE, md_valid_op=0, md_busy_op=0, md_result_op=0, all datapath registers 0.

Optional Feature:
- Macro: ALUCTRL_MD_EARLY_OUT_EN.
- Defined: in MUL, if the remaining multiplier register is 0 after an iteration, go to DONE next cycle; result is unchanged. DIV is unaffected.
- Undefined: MUL always takes exactly XLEN iterations.

Decomposition:
- Shared package aluctrl_pkg holds:
  - ALUOP_ADD/SLTU/FUNCT/IMM constants
  - 4-bit ALU op codes
  - M-extension funct3 codes (MUL..REMU) and the M funct7 value
  - md_state_t enum (IDLE, MUL, DIV, DONE)
- One sub-module, alu_muldiv_seq, contains the FSM, counter and mul/div datapath.
- The top level keeps the combinational decode and start qualification.

Test Plan:
- aluop=10, funct7=0100000, funct3=101 → aluctrl_ctrl_op=1101. aluop=11, funct7=0100000, funct3=000 → 0000 (ADDI, not SUB).
- MUL rs1=3, rs2=5 → busy for 33 cycles, md_valid_op at cycle 33, result 15. With EARLY_OUT_EN, valid at cycle 4, same result.
- MULH rs1=0x80000000, rs2=0x80000000 → 0x40000000. MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFE.
- DIV rs1=−7, rs2=2 → −3; REM same operands → −1. DIVU rs1=7, rs2=0 → 0xFFFFFFFF at cycle 2. REM rs1=0x80000000, rs2=−1 → 0.
- Start DIV, assert flush_ip at cycle 10 → IDLE at cycle 11, busy low, no md_valid_op. A new MUL 2×2 then returns 4.
- Assert rst_n low mid-MUL at cycle 7 → all outputs 0 immediately. Release, then DIVU 100/7 → 14.
